// File: rtl/attr_pingpong_ram.sv
// Two-bank attribute store: the host fills one bank while dtp reads the other.
// Banks are handed over in fill order and returned by the dtp switch pulse.
module attr_pingpong_ram #(
    parameter int THSH_WIDTH = 16,
    parameter int ATTR_WIDTH = 5,
    parameter int N_ATTR     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_samp_vld,
    input  logic [THSH_WIDTH-1:0] i_samp_data,
    output logic                  o_samp_rdy,
    input  logic                  i_stream_end,
    input  logic [ATTR_WIDTH-1:0] i_attr_ram_sel,
    output logic [THSH_WIDTH-1:0] o_attr_ram_dout,
    input  logic                  i_att_ram_switch,
    output logic                  o_is_att_ram_avai,
    output logic                  o_is_sample_done
);

    localparam logic [ATTR_WIDTH-1:0] LAST_IDX = ATTR_WIDTH'(N_ATTR - 1);

    logic [THSH_WIDTH-1:0] mem [2][N_ATTR];

    logic [1:0]            full;
    logic                  wbank;
    logic                  rbank;
    logic [ATTR_WIDTH-1:0] wr_idx;
    logic                  end_seen;

    logic xfer;
    logic discard;
    logic release_rd;

    assign o_samp_rdy        = !full[wbank];
    assign o_is_att_ram_avai = full[rbank];
    assign o_is_sample_done  = end_seen && (full == 2'b00) && (wr_idx == '0);

    assign xfer       = i_samp_vld && o_samp_rdy;
    assign discard    = i_stream_end && (wr_idx != '0);
    assign release_rd = i_att_ram_switch && full[rbank];

    // Words of a partial sample that is later discarded land in an empty bank
    // and are simply overwritten by the next fill.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wbank][wr_idx] <= i_samp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wr_idx   <= '0;
            end_seen <= 1'b0;
        end else begin
            if (discard) begin
                wr_idx <= '0;
            end else if (xfer) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx      <= '0;
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            // Only a full bank is released and only an empty bank is filled,
            // so this never collides with the fill-completion write above.
            if (release_rd) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end

            if (i_stream_end) begin
                end_seen <= 1'b1;
            end else if (xfer) begin
                end_seen <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_attr_ram_dout <= '0;
        end else if (32'(i_attr_ram_sel) >= N_ATTR) begin
            o_attr_ram_dout <= '0;
        end else begin
            o_attr_ram_dout <= mem[rbank][i_attr_ram_sel];
        end
    end

endmodule

// File: tb/tb_attr_pingpong_ram.sv
// Directed self-checking bench for attr_pingpong_ram with the default
// 32 x 16-bit banks.
module tb_attr_pingpong_ram;

    logic        clk;
    logic        rst_n;
    logic        samp_vld;
    logic [15:0] samp_data;
    logic        samp_rdy;
    logic        stream_end;
    logic [4:0]  attr_ram_sel;
    logic [15:0] attr_ram_dout;
    logic        att_ram_switch;
    logic        is_att_ram_avai;
    logic        is_sample_done;

    int total = 0;
    int bad   = 0;

    attr_pingpong_ram #(
        .THSH_WIDTH(16),
        .ATTR_WIDTH(5),
        .N_ATTR    (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_samp_vld       (samp_vld),
        .i_samp_data      (samp_data),
        .o_samp_rdy       (samp_rdy),
        .i_stream_end     (stream_end),
        .i_attr_ram_sel   (attr_ram_sel),
        .o_attr_ram_dout  (attr_ram_dout),
        .i_att_ram_switch (att_ram_switch),
        .o_is_att_ram_avai(is_att_ram_avai),
        .o_is_sample_done (is_sample_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] exp_dout;
        logic        exp_avai;
        logic        exp_rdy;
    } rd_vec_t;

    rd_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, waiting a bounded number of cycles for o_samp_rdy.
    task automatic send(input logic [15:0] d);
        bit ok;
        ok        = 1'b0;
        samp_vld  = 1'b1;
        samp_data = d;
        for (int c = 0; c < 8 && !ok; c++) begin
            if (samp_rdy) ok = 1'b1;
            step();
        end
        samp_vld = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout at %0t: word %0h not accepted, rdy=%0b required 1", $time, d, samp_rdy);
        end
    endtask

    task automatic send_sample(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + 16'(i));
    endtask

    task automatic read_check(input string name, input logic [4:0] sel, input logic [15:0] exp);
        attr_ram_sel = sel;
        step();
        check(name, 32'(attr_ram_dout), 32'(exp));
    endtask

    task automatic pulse_switch();
        att_ram_switch = 1'b1;
        step();
        att_ram_switch = 1'b0;
    endtask

    initial begin
        bit avai_dropped;

        vecs[0] = '{5'd0,  16'h1000, 1'b1, 1'b1};
        vecs[1] = '{5'd1,  16'h1001, 1'b1, 1'b1};
        vecs[2] = '{5'd5,  16'h1005, 1'b1, 1'b1};
        vecs[3] = '{5'd17, 16'h1011, 1'b1, 1'b1};
        vecs[4] = '{5'd30, 16'h101E, 1'b1, 1'b1};
        vecs[5] = '{5'd31, 16'h101F, 1'b1, 1'b1};
        vecs[6] = '{5'd10, 16'h100A, 1'b1, 1'b1};
        vecs[7] = '{5'd2,  16'h1002, 1'b1, 1'b1};

        rst_n          = 1'b0;
        samp_vld       = 1'b0;
        samp_data      = '0;
        stream_end     = 1'b0;
        attr_ram_sel   = '0;
        att_ram_switch = 1'b0;

        #3;
        check("reset_rdy",  32'(samp_rdy),        32'd1);
        check("reset_avai", 32'(is_att_ram_avai), 32'd0);
        check("reset_done", 32'(is_sample_done),  32'd0);
        check("reset_dout", 32'(attr_ram_dout),   32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single sample into bank 0, then random reads.
        send_sample(16'h1000, 31);
        check("single_avai_before_last", 32'(is_att_ram_avai), 32'd0);
        send(16'h101F);
        check("single_avai_after_last", 32'(is_att_ram_avai), 32'd1);
        check("single_rdy", 32'(samp_rdy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            attr_ram_sel = vecs[k].sel;
            step();
            check($sformatf("single_dout_sel%0d", vecs[k].sel), 32'(attr_ram_dout), 32'(vecs[k].exp_dout));
            check("single_avai_hold", 32'(is_att_ram_avai), 32'(vecs[k].exp_avai));
            check("single_rdy_hold", 32'(samp_rdy), 32'(vecs[k].exp_rdy));
        end
        pulse_switch();
        check("release_avai", 32'(is_att_ram_avai), 32'd0);

        // Spurious switch must not move rbank (now 1); the next fill goes to bank 1.
        pulse_switch();
        check("spurious_avai", 32'(is_att_ram_avai), 32'd0);
        check("spurious_rdy", 32'(samp_rdy), 32'd1);

        // Ping-pong: A -> bank 1, B -> bank 0, C stalls.
        send_sample(16'h2000, 32);
        check("pp_avai_a", 32'(is_att_ram_avai), 32'd1);
        send_sample(16'h3000, 32);
        check("pp_rdy_both_full", 32'(samp_rdy), 32'd0);
        samp_vld     = 1'b1;
        samp_data    = 16'h4000;
        attr_ram_sel = 5'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            check("pp_stall_rdy", 32'(samp_rdy), 32'd0);
        end
        check("pp_dout_a", 32'(attr_ram_dout), 32'h2003);
        samp_vld = 1'b0;
        pulse_switch();
        check("pp_switch_avai", 32'(is_att_ram_avai), 32'd1);
        check("pp_switch_rdy", 32'(samp_rdy), 32'd1);
        send(16'h4000);
        check("pp_dout_b", 32'(attr_ram_dout), 32'h3003);
        send_sample(16'h4001, 31);
        check("pp_c_done_rdy", 32'(samp_rdy), 32'd0);
        check("pp_c_done_avai", 32'(is_att_ram_avai), 32'd1);
        read_check("pp_b_sel31", 5'd31, 16'h301F);

        // Release B; C (bank 1) becomes readable immediately.
        pulse_switch();
        check("pp_avai_c", 32'(is_att_ram_avai), 32'd1);
        read_check("pp_c_sel31", 5'd31, 16'h401F);
        read_check("pp_c_sel0", 5'd0, 16'h4000);

        // Last word of D accepted in the same cycle that C is released.
        avai_dropped = 1'b0;
        for (int i = 0; i < 31; i++) begin
            send(16'h5000 + 16'(i));
            if (!is_att_ram_avai) avai_dropped = 1'b1;
        end
        samp_vld       = 1'b1;
        samp_data      = 16'h501F;
        att_ram_switch = 1'b1;
        check("sim_rdy_before", 32'(samp_rdy), 32'd1);
        step();
        samp_vld       = 1'b0;
        att_ram_switch = 1'b0;
        if (!is_att_ram_avai) avai_dropped = 1'b1;
        check("sim_avai_continuous", 32'(avai_dropped), 32'd0);
        check("sim_rdy_after", 32'(samp_rdy), 32'd1);
        read_check("sim_d_sel7", 5'd7, 16'h5007);
        read_check("sim_d_sel31", 5'd31, 16'h501F);
        pulse_switch();
        check("sim_release_avai", 32'(is_att_ram_avai), 32'd0);

        // Stream end with a partial sample: E -> bank 1, 10 words of F discarded.
        send_sample(16'h6000, 32);
        send_sample(16'h6100, 10);
        stream_end = 1'b1;
        step();
        stream_end = 1'b0;
        check("end_done_while_full", 32'(is_sample_done), 32'd0);
        check("end_avai_while_full", 32'(is_att_ram_avai), 32'd1);
        check("end_rdy", 32'(samp_rdy), 32'd1);
        pulse_switch();
        check("end_done_after_switch", 32'(is_sample_done), 32'd1);
        check("end_avai_after_switch", 32'(is_att_ram_avai), 32'd0);
        step();
        step();
        check("end_partial_not_presented", 32'(is_att_ram_avai), 32'd0);

        // A new sample after end clears end_seen; done stays low once it is consumed.
        send(16'h7000);
        check("end_cleared_by_xfer", 32'(is_sample_done), 32'd0);
        send_sample(16'h7001, 31);
        check("g_avai", 32'(is_att_ram_avai), 32'd1);
        read_check("g_sel0", 5'd0, 16'h7000);
        read_check("g_sel9", 5'd9, 16'h7009);
        pulse_switch();
        check("g_done_after_release", 32'(is_sample_done), 32'd0);

        // Async reset mid-fill: H full in bank 1, 5 words of I in bank 0.
        send_sample(16'h7100, 32);
        send_sample(16'h7200, 5);
        check("pre_reset_avai", 32'(is_att_ram_avai), 32'd1);
        attr_ram_sel = 5'd4;
        step();
        check("pre_reset_dout", 32'(attr_ram_dout), 32'h7104);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_avai", 32'(is_att_ram_avai), 32'd0);
        check("async_rdy", 32'(samp_rdy), 32'd1);
        check("async_done", 32'(is_sample_done), 32'd0);
        check("async_dout", 32'(attr_ram_dout), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        send_sample(16'h8000, 31);
        check("post_reset_avai_before_last", 32'(is_att_ram_avai), 32'd0);
        send(16'h801F);
        check("post_reset_avai_after_last", 32'(is_att_ram_avai), 32'd1);
        read_check("post_reset_sel0", 5'd0, 16'h8000);
        read_check("post_reset_sel31", 5'd31, 16'h801F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/attr_pingpong_ram.md
# attr_pingpong_ram

Double-buffered attribute store on the producer side of the `dtp` attribute-RAM interface. It accepts attribute words from the host sample stream and packs them into one of two banks. When a bank holds a complete sample, it is released to `dtp` for random-access reads. When `dtp` pulses its switch request, that bank is freed for refill, so the host can load sample k+1 while `dtp` traverses trees on sample k.

## Interface
Parameters:
- THSH_WIDTH, 16, width of one attribute word (matches threshold width in `dtp`)
- ATTR_WIDTH, 5, attribute index width
- N_ATTR, 32, attributes per sample; legal range 2..2^ATTR_WIDTH

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset; asynchronous and active-low
- i_samp_vld  in  1  host attribute word valid
- i_samp_data  in  THSH_WIDTH  host attribute word; attribute index is implied by arrival order 0..N_ATTR-1
- o_samp_rdy  out  1  store can accept a word this cycle
- i_stream_end  in  1  single-cycle pulse: host has no further samples
- i_attr_ram_sel  in  ATTR_WIDTH  attribute index requested by `dtp`
- o_attr_ram_dout  out  THSH_WIDTH  registered attribute word from the read bank
- i_att_ram_switch  in  1  single-cycle pulse from `dtp`: current sample finished, release bank
- o_is_att_ram_avai  out  1  read bank holds a complete sample
- o_is_sample_done  out  1  stream ended and every accepted complete sample has been consumed

## Operation
- Storage: two banks, each N_ATTR x THSH_WIDTH. Memory contents are not reset.
- State registers:
  - full[1:0], one flag per bank
  - wbank (write bank pointer)
  - rbank (read bank pointer)
  - wr_idx, width ATTR_WIDTH, counting 0..N_ATTR-1
  - end_seen
- Write path:
  - o_samp_rdy = !full[wbank], decoded from registers.
  - Transfer happens when i_samp_vld && o_samp_rdy: mem[wbank][wr_idx] <= i_samp_data.
  - If wr_idx == N_ATTR-1: wr_idx <= 0, full[wbank] <= 1, wbank toggles. Otherwise wr_idx increments.
- Read path:
  - Every cycle, o_attr_ram_dout <= mem[rbank][i_attr_ram_sel].
  - If i_attr_ram_sel >= N_ATTR, o_attr_ram_dout <= 0.
- Availability: o_is_att_ram_avai = full[rbank], decoded from registers.
- Release: i_att_ram_switch && full[rbank] sets full[rbank] <= 0 and toggles rbank. A switch while !full[rbank] is ignored and changes no state.
- Stream end:
  - i_stream_end sets end_seen.
  - If wr_idx != 0 in that same cycle, the partial sample is discarded: wr_idx <= 0, full[wbank] stays 0, wbank is unchanged. Any word accepted in the same cycle is discarded with it.
  - end_seen clears on the first transfer accepted after it was set.
  - When a transfer and i_stream_end occur in the same cycle, the end pulse wins: end_seen = 1.
- Done: o_is_sample_done = end_seen && !full[0] && !full[1] && wr_idx == 0, decoded from registers.
- Simultaneous events:
  - Fill completion on wbank and release on rbank in the same cycle are both applied.
  - The two can never target the same bank, because only an empty bank is written and only a full bank is released.

## Timing
- Reset values (asynchronous, while rst_n low):
  - full = 00, wbank = 0, rbank = 0, wr_idx = 0, end_seen = 0
  - o_attr_ram_dout = 0
  - o_samp_rdy = 1, o_is_att_ram_avai = 0, o_is_sample_done = 0
- Reset mid-operation discards all samples, including partial ones; outputs take their reset values immediately.
- Read latency: one cycle from i_attr_ram_sel to o_attr_ram_dout.
- Switch timing:
  - The pulse is sampled at edge T.
  - If the other bank is already full, o_is_att_ram_avai stays 1 after T and dout reflects the new bank from edge T+1.
  - If the other bank is not full, o_is_att_ram_avai is 0 after T.
- Fill to availability: the last word of a sample is accepted at edge T.
  - If rbank points at that bank, o_is_att_ram_avai = 1 after T.
  - Otherwise the sample waits until the current read bank is released.
- Host throughput: one word per cycle while a bank is empty. o_samp_rdy drops the cycle after both banks are full, and rises the cycle after a release frees wbank.
- Sample order is strict FIFO: samples are presented to `dtp` in acceptance order.

## Test plan
- Single sample:
  - Stimulus: after reset, stream words 0x1000+i for i = 0..31, one per cycle; then drive sel = 0..31.
  - Required: avai rises the cycle after word 31; dout = 0x1000+sel one cycle after each sel; rdy stays 1 (bank 1 empty).
- Ping-pong backpressure:
  - Stimulus: stream three samples back-to-back with no switch.
  - Required: rdy = 0 after the 64th word; the third sample stalls.
  - Stimulus: pulse switch.
  - Required: avai stays 1, dout now comes from sample 2, and rdy = 1 on the next cycle; sample 3 then completes.
- Spurious switch:
  - Stimulus: pulse switch while avai = 0.
  - Required: rbank, full and avai are unchanged.
- Stream end with partial sample:
  - Stimulus: load 1 full sample plus 10 words of the next, pulse i_stream_end.
  - Required: done stays 0 while bank 0 is full. After switch: done = 1 and avai = 0; the partial sample is never presented.
- Simultaneous events:
  - Stimulus: the last word of sample 2 is accepted in the same cycle that switch releases sample 1.
  - Required: avai = 1 continuously and sample 2 data is read correctly.
- Async reset mid-fill:
  - Stimulus: assert rst_n low mid-fill for 3 cycles.
  - Required: outputs go to reset values without waiting for a clock edge; the next fill starts at index 0 of bank 0.
